board_commit_writer: RTL and testbench

- Write-side counterpart to the 6x6 neighbourhood sampler. Owns the registered playfield and commits a locked piece's 6x6 occupancy mask into it.
- After committing, scans for full rows and collapses them, then reports how many lines were cleared.
- Sits between the game FSM, which issues lock requests, and the game_state packer, which exports screen into state.screen.

---
 rtl/game_state_pkg.sv | 22 ++
 rtl/board_commit_writer_if.sv | 32 +++
 rtl/board_row_collapse.sv | 31 +++
 rtl/board_commit_writer.sv | 156 +++++++++++++++
 tb/tb_board_commit_writer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_state_pkg.sv
// Shared playfield definitions for the game-state blocks: board defaults,
// screen/mask types and the commit writer's state encoding.
package game_state_pkg;

    localparam int BOARD_WIDTH_DEFAULT  = 10;
    localparam int BOARD_HEIGHT_DEFAULT = 20;
    localparam int WINDOW_SIZE          = 6;

    // screen[x][y]: BOARD_WIDTH columns of BOARD_HEIGHT bits, (0,0) top-left.
    typedef logic [BOARD_WIDTH_DEFAULT-1:0][BOARD_HEIGHT_DEFAULT-1:0] screen_t;

    // mask[lx][ly]: WINDOW_SIZE columns of WINDOW_SIZE bits, 1 = piece cell.
    typedef logic [WINDOW_SIZE-1:0][WINDOW_SIZE-1:0] mask_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SCAN,
        DONE
    } commit_state_t;

endpackage

// File: rtl/board_commit_writer_if.sv
// Lock-request channel between the game FSM (master) and the commit writer
// (slave), including the per-commit result flags.
interface board_commit_writer_if
    import game_state_pkg::*;
#(
    parameter int BOARD_WIDTH  = BOARD_WIDTH_DEFAULT,
    parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEFAULT
);
    localparam int XW = $clog2(BOARD_WIDTH);
    localparam int YW = $clog2(BOARD_HEIGHT);

    logic          commit_valid;
    logic          commit_ready;
    logic [XW-1:0] piece_x;
    logic [YW-1:0] piece_y;
    mask_t         mask;
    logic          done;
    logic [2:0]    lines_cleared;
    logic          collision;
    logic          oob;

    modport master (
        output commit_valid, piece_x, piece_y, mask,
        input  commit_ready, done, lines_cleared, collision, oob
    );

    modport slave (
        input  commit_valid, piece_x, piece_y, mask,
        output commit_ready, done, lines_cleared, collision, oob
    );

endinterface

// File: rtl/board_row_collapse.sv
// Combinational full-row test for row r and the board with row r removed
// (rows above shift down one, top row refilled with zeros).
module board_row_collapse
    import game_state_pkg::*;
#(
    parameter int BOARD_WIDTH  = BOARD_WIDTH_DEFAULT,
    parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEFAULT
) (
    input  logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] screen,
    input  logic [$clog2(BOARD_HEIGHT)-1:0]          r,
    output logic                                     row_full,
    output logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] collapsed
);

    always_comb begin
        // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
        row_full  = 1'b1;
        collapsed = screen;
        for (int x = 0; x < BOARD_WIDTH; x++) begin
            row_full = row_full & screen[x][r];
            for (int y = 0; y < BOARD_HEIGHT; y++) begin
                if (y == 0) begin
                    collapsed[x][y] = 1'b0;
                end else if (y <= int'(r)) begin
                    collapsed[x][y] = screen[x][y-1];
                end
            end
        end
    end

endmodule

// File: rtl/board_commit_writer.sv
// Owns the registered playfield: ORs a locked piece's 6x6 window into it one
// column per cycle, then scans bottom-up collapsing full rows.
module board_commit_writer
    import game_state_pkg::*;
#(
    parameter int BOARD_WIDTH  = BOARD_WIDTH_DEFAULT,
    parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    board_commit_writer_if.slave                     commit,
    input  logic                                     clear_board,
    output logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] screen,
    output logic                                     busy
);

    localparam int XW = $clog2(BOARD_WIDTH);
    localparam int YW = $clog2(BOARD_HEIGHT);
    localparam logic signed [5:0] WIDTH_S  = 6'(BOARD_WIDTH);
    localparam logic signed [5:0] HEIGHT_S = 6'(BOARD_HEIGHT);

    typedef logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] board_t;

    commit_state_t state;
    board_t        screen_q;
    logic [XW-1:0] lat_x;
    logic [YW-1:0] lat_y;
    mask_t         lat_mask;
    logic [2:0]    col_idx;
    logic [YW-1:0] row_idx;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic [2:0]    lines_q;
    logic          coll_q;
    logic          oob_q;

    board_t           wr_screen;
    logic             wr_coll;
    logic             wr_oob;
    logic signed [5:0] wx;
    logic signed [5:0] wy;

    logic   row_full;
    board_t collapsed;

    board_row_collapse #(
        .BOARD_WIDTH (BOARD_WIDTH),
        .BOARD_HEIGHT(BOARD_HEIGHT)
    ) u_collapse (
        .screen   (screen_q),
        .r        (row_idx),
        .row_full (row_full),
        .collapsed(collapsed)
    );

    // One window column per cycle; signed 6-bit coordinates so x-1 / y-1 = -1 reads as off-board.
    always_comb begin
        wr_screen = screen_q;
        wr_coll   = 1'b0;
        wr_oob    = 1'b0;
        wy        = '0;
        wx        = $signed({{(6-XW){1'b0}}, lat_x}) + $signed({3'b000, col_idx}) - 6'sd1;
        for (int ly = 0; ly < WINDOW_SIZE; ly++) begin
            wy = $signed({{(6-YW){1'b0}}, lat_y}) + $signed(6'(ly)) - 6'sd1;
            if (lat_mask[col_idx][ly]) begin
                if (wx >= 6'sd0 && wx < WIDTH_S && wy >= 6'sd0 && wy < HEIGHT_S) begin
                    if (wr_screen[wx[XW-1:0]][wy[YW-1:0]]) begin
                        wr_coll = 1'b1;
                    end
                    wr_screen[wx[XW-1:0]][wy[YW-1:0]] = 1'b1;
                end else begin
                    wr_oob = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the playfield is a register array, not a RAM, so it is reset like any other state.
            screen_q <= '0;
            state    <= IDLE;
            lat_x    <= '0;
            lat_y    <= '0;
            lat_mask <= '0;
            col_idx  <= '0;
            row_idx  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lines_q  <= '0;
            coll_q   <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees start-of-cycle state.
            case (state)
                IDLE: begin
                    if (clear_board) begin
                        screen_q <= '0;
                    end else if (commit.commit_valid) begin
                        lat_x    <= commit.piece_x;
                        lat_y    <= commit.piece_y;
                        lat_mask <= commit.mask;
                        col_idx  <= '0;
                        lines_q  <= '0;
                        coll_q   <= 1'b0;
                        oob_q    <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    screen_q <= wr_screen;
                    if (wr_coll) coll_q <= 1'b1;
                    if (wr_oob)  oob_q  <= 1'b1;
                    if (col_idx == 3'(WINDOW_SIZE - 1)) begin
                        row_idx <= YW'(BOARD_HEIGHT - 1);
                        state   <= SCAN;
                    end else begin
                        col_idx <= col_idx + 3'd1;
                    end
                end
                SCAN: begin
                    // A collapsed row is rescanned at the same index: the row above just moved in.
                    if (row_full) begin
                        screen_q <= collapsed;
                        if (lines_q != 3'd7) lines_q <= lines_q + 3'd1;
                    end else if (row_idx == '0) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        row_idx <= row_idx - 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign screen               = screen_q;
    assign busy                 = busy_q;
    assign commit.commit_ready  = ready_q;
    assign commit.done          = done_q;
    assign commit.lines_cleared = lines_q;
    assign commit.collision     = coll_q;
    assign commit.oob           = oob_q;

endmodule

// File: tb/tb_board_commit_writer.sv
// Checks board_commit_writer against a cell-array model of the playfield:
// directed piece placements, line clears, edge cases, then random commits.
module tb_board_commit_writer;
    import game_state_pkg::*;

    localparam int W = BOARD_WIDTH_DEFAULT;
    localparam int H = BOARD_HEIGHT_DEFAULT;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    clear_board = 1'b0;
    screen_t screen;
    logic    busy;

    board_commit_writer_if bus ();

    board_commit_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .commit     (bus),
        .clear_board(clear_board),
        .screen     (screen),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit model [W][H];
    int exp_lc   = 0;
    bit exp_coll = 1'b0;
    bit exp_oob  = 1'b0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic screen_t packed_model();
        screen_t p;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                p[x][y] = model[x][y];
        return p;
    endfunction

    task automatic zero_model();
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                model[x][y] = 1'b0;
    endtask

    // Whenever the block is idle the visible board and last-commit flags must match the model.
    always @(negedge clk) begin
        if (rst_n && model_on) begin
            check("ready_is_not_busy", bus.commit_ready, !busy);
            if (!busy) begin
                check("idle_screen", screen, packed_model());
                check("idle_lines_cleared", bus.lines_cleared, exp_lc);
                check("idle_collision", bus.collision, exp_coll);
                check("idle_oob", bus.oob, exp_oob);
                check("idle_done_low", bus.done, 1'b0);
            end
        end
    end

    task automatic do_clear();
        @(negedge clk);
        clear_board = 1'b1;
        @(posedge clk);
        #1;
        zero_model();
        check("clear_screen", screen, '0);
        check("clear_not_busy", busy, 1'b0);
        clear_board = 1'b0;
    endtask

    // Issues one lock request, holds it until done, and checks it against the model.
    task automatic do_commit(input int px, input int py, input mask_t m, input bit with_clear,
                             input int clr_at, output int dcyc, output int lc_o,
                             output bit co, output bit oo);
        bit nb  [W][H];
        bit tmp [W][H];
        int n;
        int dst;
        bit full;
        bit ec;
        bit eo;
        int wx;
        int wy;
        dcyc = -1;
        lc_o = -1;
        co   = 1'b0;
        oo   = 1'b0;

        @(negedge clk);
        bus.piece_x      = 4'(px);
        bus.piece_y      = 5'(py);
        bus.mask         = m;
        bus.commit_valid = 1'b1;
        if (with_clear) begin
            clear_board = 1'b1;
            @(posedge clk);
            #1;
            zero_model();
            check("clr_wins_no_accept", busy, 1'b0);
            check("clr_wins_screen", screen, '0);
            clear_board = 1'b0;
        end

        nb = model;
        ec = 1'b0;
        eo = 1'b0;
        for (int lx = 0; lx < WINDOW_SIZE; lx++) begin
            for (int ly = 0; ly < WINDOW_SIZE; ly++) begin
                if (m[lx][ly]) begin
                    wx = px + lx - 1;
                    wy = py + ly - 1;
                    if (wx >= 0 && wx < W && wy >= 0 && wy < H) begin
                        if (nb[wx][wy]) ec = 1'b1;
                        nb[wx][wy] = 1'b1;
                    end else begin
                        eo = 1'b1;
                    end
                end
            end
        end
        // Keep non-full rows, packed toward the bottom in their original order.
        n   = 0;
        dst = H - 1;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                tmp[x][y] = 1'b0;
        for (int y = H - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int x = 0; x < W; x++) full = full & nb[x][y];
            if (full) begin
                n++;
            end else begin
                for (int x = 0; x < W; x++) tmp[x][dst] = nb[x][y];
                dst--;
            end
        end

        @(posedge clk);
        #1;
        check("accepted", busy, 1'b1);
        if (busy !== 1'b1) begin
            bus.commit_valid = 1'b0;
            return;
        end

        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            clear_board = (k == clr_at);
            if (bus.done === 1'b1) begin
                dcyc = k;
                break;
            end
        end
        clear_board      = 1'b0;
        bus.commit_valid = 1'b0;
        if (dcyc < 0) begin
            check("done_timeout", 1'b0, 1'b1);
            return;
        end
        lc_o = int'(bus.lines_cleared);
        co   = bus.collision;
        oo   = bus.oob;
        check("done_latency", dcyc, 6 + H + n + 1);
        check("done_busy", busy, 1'b1);
        check("done_lines_cleared", bus.lines_cleared, (n > 7) ? 7 : n);
        check("done_collision", bus.collision, ec);
        check("done_oob", bus.oob, eo);
        model    = tmp;
        exp_lc   = (n > 7) ? 7 : n;
        exp_coll = ec;
        exp_oob  = eo;
    endtask

    initial begin
        mask_t m;
        int    dcyc;
        int    lc;
        bit    co;
        bit    oo;

        bus.commit_valid = 1'b0;
        bus.piece_x      = '0;
        bus.piece_y      = '0;
        bus.mask         = '0;
        zero_model();

        repeat (2) @(negedge clk);
        check("rst_screen", screen, '0);
        check("rst_ready", bus.commit_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_lines", bus.lines_cleared, 3'd0);
        check("rst_flags", {bus.collision, bus.oob}, 2'b00);
        rst_n    = 1'b1;
        model_on = 1'b1;

        // O piece at (4,0).
        m = '0;
        m[1][1] = 1'b1; m[1][2] = 1'b1; m[2][1] = 1'b1; m[2][2] = 1'b1;
        do_commit(4, 0, m, 1'b0, 0, dcyc, lc, co, oo);
        check("o_cells", {screen[4][0], screen[4][1], screen[5][0], screen[5][1]}, 4'hf);
        check("o_popcount", $countones(screen), 4);
        check("o_done_cycle", dcyc, 27);
        check("o_flags", {lc[2:0], co, oo}, 5'b0);

        // Row 19 filled at x=0..8, then a vertical I at x=9 clears it.
        do_clear();
        m = '0;
        for (int i = 0; i < 6; i++) m[i][1] = 1'b1;
        do_commit(1, 19, m, 1'b0, 0, dcyc, lc, co, oo);
        m = '0;
        for (int i = 0; i < 3; i++) m[i][1] = 1'b1;
        do_commit(7, 19, m, 1'b0, 0, dcyc, lc, co, oo);
        m = '0;
        for (int i = 0; i < 4; i++) m[1][i] = 1'b1;
        do_commit(9, 17, m, 1'b0, 0, dcyc, lc, co, oo);
        check("single_lines", lc, 1);
        check("single_done_cycle", dcyc, 28);
        check("single_col9", screen[9][19:16], 4'b1110);
        check("single_popcount", $countones(screen), 3);

        // Tetris: rows 16..19 full except x=0.
        do_clear();
        m = '0;
        for (int i = 0; i < 6; i++) m[i][3:0] = 4'hf;
        do_commit(2, 17, m, 1'b0, 0, dcyc, lc, co, oo);
        m = '0;
        for (int i = 0; i < 3; i++) m[i][3:0] = 4'hf;
        do_commit(8, 17, m, 1'b0, 0, dcyc, lc, co, oo);
        m = '0;
        m[1][3:0] = 4'hf;
        do_commit(0, 17, m, 1'b0, 0, dcyc, lc, co, oo);
        check("tetris_lines", lc, 4);
        check("tetris_done_cycle", dcyc, 31);
        check("tetris_screen", screen, '0);

        // Left edge: column lx=0 lands at x=-1 and is dropped.
        m = '0;
        m[0][2] = 1'b1; m[0][0] = 1'b1; m[1][2] = 1'b1;
        do_commit(0, 5, m, 1'b0, 0, dcyc, lc, co, oo);
        check("oob_flag", oo, 1'b1);
        check("oob_coll_clear", co, 1'b0);
        check("oob_inbounds_written", screen[0][6], 1'b1);
        check("oob_popcount", $countones(screen), 1);
        m = '0;
        m[1][2] = 1'b1;
        do_commit(0, 5, m, 1'b0, 0, dcyc, lc, co, oo);
        check("coll_flag", co, 1'b1);
        check("coll_oob_clear", oo, 1'b0);
        check("coll_cell_kept", screen[0][6], 1'b1);
        // Bottom edge: wy=23 dropped, wy=19 written.
        m = '0;
        m[1][5] = 1'b1; m[1][1] = 1'b1;
        do_commit(3, 19, m, 1'b0, 0, dcyc, lc, co, oo);
        check("oob_bottom_flag", oo, 1'b1);
        check("oob_bottom_cell", screen[3][19], 1'b1);

        // clear_board with commit_valid: clear first, accept next cycle; clear ignored while busy.
        m = '0;
        m[2][2] = 1'b1; m[3][2] = 1'b1;
        do_commit(5, 10, m, 1'b1, 12, dcyc, lc, co, oo);
        check("hs_popcount", $countones(screen), 2);
        check("hs_cells", {screen[6][11], screen[7][11]}, 2'b11);

        // Reset in the middle of WRITE.
        @(negedge clk);
        bus.mask         = 6'h3f;
        bus.piece_x      = 4'd3;
        bus.piece_y      = 5'd3;
        bus.commit_valid = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_accepted", busy, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.commit_valid = 1'b0;
        zero_model();
        exp_lc   = 0;
        exp_coll = 1'b0;
        exp_oob  = 1'b0;
        #1;
        check("mid_rst_screen", screen, '0);
        check("mid_rst_ready", bus.commit_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_lines", bus.lines_cleared, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 7) do_clear();
            m = '0;
            for (int lx = 0; lx < WINDOW_SIZE; lx++)
                for (int ly = 0; ly < WINDOW_SIZE; ly++)
                    m[lx][ly] = ($urandom_range(0, 3) == 0);
            do_commit($urandom_range(0, W - 1), $urandom_range(0, H - 1), m, (i % 7 == 3),
                      (i % 5 == 0) ? $urandom_range(1, 26) : 0, dcyc, lc, co, oo);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
